lstm_seq_ctrl: RTL and testbench
================================

// Module: lstm_seq_ctrl
// PURPOSE
//  Sequencer in front of the lstm_layers stack. Zeroes the per-layer C/h state at each sequence start.
//  Then feeds seq_len samples one at a time: a sample is issued, the controller waits for the stack's y, then issues the next.
//  Returns each y on a valid/ready stream, with m_last marking the final element. Weights are configured elsewhere.
// PARAMETERS
//  LAYERS   3     layer count; sets the width of the C_in/h_in buses
//  WIDTH    16    signed sample width
//  MAX_LEN  256   maximum sequence length; LEN_W = $clog2(MAX_LEN+1)
//  TIMEOUT  1024  watchdog limit in cycles; used only with LSTM_SEQ_TIMEOUT_EN
// PORTS
//  clk          in   1             clock
//  rst          in   1             reset, asynchronous, active-low
//  start        in   1             pulse: begin a sequence (honoured only in IDLE)
//  seq_len      in   LEN_W         element count, sampled at the start pulse
//  busy         out  1             state != IDLE
//  s_data       in   WIDTH         input sample
//  s_valid      in   1             input sample valid
//  s_ready      out  1             input accept
//  m_data       out  WIDTH         result y
//  m_last       out  1             final element of the sequence
//  m_valid      out  1             result valid
//  m_ready      in   1             result accept
//  lstm_ready   in   1             layer-0 ready from the stack
//  C_in         out  LAYERS*WIDTH  initial cell state (all zero)
//  C_in_valid   out  LAYERS        cell-state load strobe
//  h_in         out  LAYERS*WIDTH  initial hidden state (all zero)
//  h_in_valid   out  LAYERS        hidden-state load strobe
//  x_in         out  WIDTH         sample to the stack
//  x_in_valid   out  1             one-cycle sample strobe
//  y_out        in   WIDTH         stack output
//  y_valid      in   1             stack output valid
//  timeout_err  out  1             sticky watchdog flag
// BEHAVIOUR
//  Reset: every output 0, state IDLE, counters 0. Reset mid-sequence aborts it; the stack is re-zeroed at the next INIT.
//  States: IDLE -> INIT -> FEED <-> WAIT -> DRAIN -> IDLE.
//  IDLE: start && seq_len!=0 -> latch len, cnt=0, go to INIT. A start with seq_len==0 is ignored. start outside IDLE is ignored.
//  INIT: one cycle with C_in_valid = h_in_valid = '1 and C_in = h_in = 0 -> FEED.
//  FEED:
//   - s_ready = lstm_ready & ~m_valid.
//   - On an s handshake at cycle t: x_in <= s_data and x_in_valid = 1 at t+1 for exactly one cycle -> WAIT.
//  WAIT:
//   - s_ready = 0.
//   - y_valid at cycle u: m_data <= y_out, m_valid = 1 at u+1, m_last = (cnt==len-1), cnt++.
//   - Then -> DRAIN if last, else -> FEED.
//  m_valid/m_data/m_last are held until m_ready. If m_ready arrives in the same cycle as a new capture, the capture wins.
//  DRAIN: wait until the m handshake completes -> IDLE. busy drops the cycle after.
//  y_valid outside WAIT is ignored. x_in_valid is never asserted outside FEED->WAIT.
//  Exactly one sample is in flight; no y is lost because issue requires ~m_valid.
//  cnt is LEN_W bits and cannot wrap, because len <= MAX_LEN.
// CONFIGURATION
//  LSTM_SEQ_TIMEOUT_EN defined:
//   - TIMEOUT consecutive WAIT cycles without y_valid -> timeout_err=1 (sticky), state -> IDLE, no m_valid.
//   - timeout_err clears on the next accepted start.
//  Not defined: WAIT lasts indefinitely; timeout_err tied 0; no watchdog counter is built.
// STRUCTURE
//  lstm_seq_pkg: seq_state_t enum {IDLE,INIT,FEED,WAIT,DRAIN}; LEN_W helper function.
//  Sub-module lstm_seq_watchdog (clear/enable/expired counter), instantiated only under the macro.
// TESTING
//  1. len=3, samples 0x0100/0x0200/0x0300; stack stub returns x+1 after 4 cycles.
//     -> one INIT cycle with C_in_valid=h_in_valid=3'b111 and zero data.
//     -> m_data 0x0101/0x0201/0x0301; m_last on the 3rd only.
//  2. m_ready low for 10 cycles after the 1st result -> m_valid/m_data held; s_ready=0; no x_in_valid; resumes afterwards.
//  3. start with seq_len=0 -> busy stays 0. start while busy -> ignored; len unchanged.
//  4. rst low during WAIT -> all outputs 0 immediately (asynchronous). After release, a new start performs INIT again.
//  5. Macro on, TIMEOUT=16, stub silent -> timeout_err=1 after 16 WAIT cycles, busy=0. Macro off -> busy stays 1.
//  6. lstm_ready=0 while s_valid=1 -> s_ready=0, no x_in_valid. Release -> sample issued the next cycle.

Source files
------------

// File: rtl/lstm_seq_pkg.sv
// Shared types and helpers for the LSTM sequence controller.
//   seq_state_t    : controller FSM encoding (IDLE, INIT, FEED, WAIT, DRAIN)
//   lstm_seq_len_w : width of the length/count fields for a given MAX_LEN
package lstm_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    FEED  = 3'd2,
    WAIT  = 3'd3,
    DRAIN = 3'd4
  } seq_state_t;

  // Enough bits to hold MAX_LEN itself, not just MAX_LEN-1.
  function automatic int unsigned lstm_seq_len_w(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/lstm_seq_watchdog.sv
// Counts consecutive enabled cycles and flags the LIMIT-th one.
//   clk, rst : clock, asynchronous active-low reset
//   clear    : synchronous counter clear (has priority over enable)
//   enable   : count this cycle
//   expired  : high during the LIMIT-th consecutive enabled cycle
module lstm_seq_watchdog #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expired = enable && !clear && (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/lstm_seq_ctrl.sv
// Sequencer in front of the lstm_layers stack. Zeroes per-layer C/h state at
// each sequence start, then issues seq_len samples one at a time, waiting for
// the stack's y before the next issue, and returns every y on a valid/ready
// stream with m_last on the final element.
// Optional feature macro: LSTM_SEQ_TIMEOUT_EN (WAIT watchdog, sticky timeout_err).
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   start, seq_len, busy     sequence control / status
//   s_data/s_valid/s_ready   input sample stream
//   m_data/m_last/m_valid/m_ready  result stream
//   lstm_ready               layer-0 ready from the stack
//   C_in/C_in_valid, h_in/h_in_valid  state zeroing towards the stack
//   x_in/x_in_valid          sample towards the stack (one-cycle strobe)
//   y_out/y_valid            stack result
//   timeout_err              sticky watchdog flag (0 without the macro)
module lstm_seq_ctrl
  import lstm_seq_pkg::*;
#(
  parameter int unsigned LAYERS  = 3,
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned MAX_LEN = 256,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned LEN_W   = lstm_seq_len_w(MAX_LEN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN_W-1:0]        seq_len,
  output logic                    busy,
  input  logic [WIDTH-1:0]        s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [WIDTH-1:0]        m_data,
  output logic                    m_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  input  logic                    lstm_ready,
  output logic [LAYERS*WIDTH-1:0] C_in,
  output logic [LAYERS-1:0]       C_in_valid,
  output logic [LAYERS*WIDTH-1:0] h_in,
  output logic [LAYERS-1:0]       h_in_valid,
  output logic [WIDTH-1:0]        x_in,
  output logic                    x_in_valid,
  input  logic [WIDTH-1:0]        y_out,
  input  logic                    y_valid,
  output logic                    timeout_err
);

  seq_state_t       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] x_data_q, x_data_d;
  logic             x_valid_q, x_valid_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic             m_valid_q, m_valid_d;
  logic             m_last_q, m_last_d;

  logic start_accept;
  logic issue;
  logic last_elem;
  logic wd_expired;

  assign start_accept = (state_q == IDLE) && start && (seq_len != '0);
  // Issue is gated by ~m_valid so a new y can never overwrite an unread one.
  assign s_ready      = (state_q == FEED) && lstm_ready && !m_valid_q;
  assign issue        = s_valid && s_ready;
  assign last_elem    = (cnt_q == len_q - LEN_W'(1));

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    x_data_d  = x_data_q;
    x_valid_d = 1'b0;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;

    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (start_accept) begin
          len_d   = seq_len;
          cnt_d   = '0;
          state_d = INIT;
        end
      end
      INIT: state_d = FEED;
      FEED: begin
        if (issue) begin
          x_data_d  = s_data;
          x_valid_d = 1'b1;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        // A capture overrides a same-cycle m handshake clear above.
        if (y_valid) begin
          m_data_d  = y_out;
          m_valid_d = 1'b1;
          m_last_d  = last_elem;
          cnt_d     = cnt_q + LEN_W'(1);
          state_d   = last_elem ? DRAIN : FEED;
        end else if (wd_expired) begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (m_valid_q && m_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      x_data_q  <= '0;
      x_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      x_data_q  <= x_data_d;
      x_valid_q <= x_valid_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
    end
  end

`ifdef LSTM_SEQ_TIMEOUT_EN
  logic wd_enable;
  logic timeout_err_q;

  assign wd_enable = (state_q == WAIT) && !y_valid;

  lstm_seq_watchdog #(
    .LIMIT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (!wd_enable),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timeout_err_q <= 1'b0;
    end else if (start_accept) begin
      timeout_err_q <= 1'b0;
    end else if (wd_expired) begin
      timeout_err_q <= 1'b1;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign wd_expired  = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign busy       = (state_q != IDLE);
  assign C_in       = '0;
  assign h_in       = '0;
  assign C_in_valid = {LAYERS{state_q == INIT}};
  assign h_in_valid = {LAYERS{state_q == INIT}};
  assign x_in       = x_data_q;
  assign x_in_valid = x_valid_q;
  assign m_data     = m_data_q;
  assign m_valid    = m_valid_q;
  assign m_last     = m_last_q;

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// Self-checking bench for lstm_seq_ctrl: a stack stub answering y = x + 1
// four cycles after each x_in_valid, a scoreboard queue of expected results
// filled at every s handshake and drained at every m handshake, a table of
// sequences, and hand-written corner-case sequences.
module tb_lstm_seq_ctrl;

  localparam int unsigned LAYERS  = 3;
  localparam int unsigned WIDTH   = 16;
  localparam int unsigned MAX_LEN = 256;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);

  logic                    clk;
  logic                    rst;
  logic                    start;
  logic [LEN_W-1:0]        seq_len;
  logic                    busy;
  logic [WIDTH-1:0]        s_data;
  logic                    s_valid;
  logic                    s_ready;
  logic [WIDTH-1:0]        m_data;
  logic                    m_last;
  logic                    m_valid;
  logic                    m_ready;
  logic                    lstm_ready;
  logic [LAYERS*WIDTH-1:0] C_in;
  logic [LAYERS-1:0]       C_in_valid;
  logic [LAYERS*WIDTH-1:0] h_in;
  logic [LAYERS-1:0]       h_in_valid;
  logic [WIDTH-1:0]        x_in;
  logic                    x_in_valid;
  logic [WIDTH-1:0]        y_out;
  logic                    y_valid;
  logic                    timeout_err;

  lstm_seq_ctrl #(
    .LAYERS (LAYERS),
    .WIDTH  (WIDTH),
    .MAX_LEN(MAX_LEN),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .seq_len    (seq_len),
    .busy       (busy),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .lstm_ready (lstm_ready),
    .C_in       (C_in),
    .C_in_valid (C_in_valid),
    .h_in       (h_in),
    .h_in_valid (h_in_valid),
    .x_in       (x_in),
    .x_in_valid (x_in_valid),
    .y_out      (y_out),
    .y_valid    (y_valid),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             last;
  } vec_t;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
  } exp_t;

  vec_t tbl[5];
  exp_t sb[$];

  int n_vec;
  int n_bad;

  logic [WIDTH-1:0] exp_y;
  logic             exp_last;
  logic [WIDTH-1:0] last_x;
  logic             x_pend;
  logic             prev_xv;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Stack stub: y = x + 1, four cycles after the strobe.
  logic             stub_en;
  logic             stub_pend;
  int               stub_dly;
  logic [WIDTH-1:0] stub_x;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      stub_pend <= 1'b0;
      stub_dly  <= 0;
      stub_x    <= '0;
      y_valid   <= 1'b0;
      y_out     <= '0;
    end else begin
      y_valid <= 1'b0;
      if (x_in_valid && stub_en) begin
        stub_pend <= 1'b1;
        stub_dly  <= 3;
        stub_x    <= x_in;
      end else if (stub_pend) begin
        if (stub_dly == 0) begin
          y_valid   <= 1'b1;
          y_out     <= stub_x + WIDTH'(1);
          stub_pend <= 1'b0;
        end else begin
          stub_dly <= stub_dly - 1;
        end
      end
    end
  end

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      if (x_in_valid) begin
        check("x_in_valid expected", x_pend, 1'b1);
        check("x_in data", x_in, last_x);
        check("x_in_valid one cycle", prev_xv, 1'b0);
        x_pend = 1'b0;
      end
      prev_xv = x_in_valid;
      if (s_valid && s_ready) begin
        sb.push_back({exp_y, exp_last});
        last_x = s_data;
        x_pend = 1'b1;
      end
      if (m_valid && m_ready) begin
        check("scoreboard has entry", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("m_data", m_data, e.data);
          check("m_last", m_last, e.last);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_seq(input int len);
    start   = 1'b1;
    seq_len = LEN_W'(len);
    tick();
    start   = 1'b0;
  endtask

  task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic last);
    logic hs;
    hs       = 1'b0;
    s_data   = x;
    s_valid  = 1'b1;
    exp_y    = y;
    exp_last = last;
    for (int i = 0; i < 200; i++) begin
      hs = s_ready;
      tick();
      if (hs) break;
    end
    check("s handshake within budget", hs, 1'b1);
    s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (!busy) break;
      tick();
    end
    check("busy drops within budget", busy, 1'b0);
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    sb.delete();
    x_pend  = 1'b0;
    prev_xv = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    int i;
    int j;
    n_vec      = 0;
    n_bad      = 0;
    rst        = 1'b0;
    start      = 1'b0;
    seq_len    = '0;
    s_valid    = 1'b0;
    s_data     = '0;
    m_ready    = 1'b1;
    lstm_ready = 1'b1;
    stub_en    = 1'b1;
    exp_y      = '0;
    exp_last   = 1'b0;
    last_x     = '0;
    x_pend     = 1'b0;
    prev_xv    = 1'b0;

    tbl[0] = '{x: 16'h0100, y: 16'h0101, last: 1'b0};
    tbl[1] = '{x: 16'h0200, y: 16'h0201, last: 1'b0};
    tbl[2] = '{x: 16'h0300, y: 16'h0301, last: 1'b1};
    tbl[3] = '{x: 16'hFFFF, y: 16'h0000, last: 1'b0};
    tbl[4] = '{x: 16'h7FFF, y: 16'h8000, last: 1'b1};

    // Reset state.
    repeat (3) tick();
    check("reset busy", busy, 1'b0);
    check("reset m_valid", m_valid, 1'b0);
    check("reset m_data", m_data, '0);
    check("reset s_ready", s_ready, 1'b0);
    check("reset x_in_valid", x_in_valid, 1'b0);
    check("reset C_in_valid", C_in_valid, '0);
    check("reset h_in_valid", h_in_valid, '0);
    check("reset timeout_err", timeout_err, 1'b0);
    rst = 1'b1;
    tick();

    // Table-driven sequences; each group ends at a record with last set.
    i = 0;
    while (i < 5) begin
      j = i;
      while (!tbl[j].last) j++;
      start_seq(j - i + 1);
      check("INIT C_in_valid", C_in_valid, 3'b111);
      check("INIT h_in_valid", h_in_valid, 3'b111);
      check("INIT C_in", C_in, '0);
      check("INIT h_in", h_in, '0);
      check("INIT busy", busy, 1'b1);
      tick();
      check("INIT single cycle", C_in_valid, '0);
      for (int k = i; k <= j; k++) send(tbl[k].x, tbl[k].y, tbl[k].last);
      wait_idle();
      i = j + 1;
    end

    // Result backpressure holds m_* and blocks the next issue.
    m_ready = 1'b0;
    start_seq(2);
    tick();
    send(16'h0A00, 16'h0A01, 1'b0);
    s_data   = 16'h0B00;
    s_valid  = 1'b1;
    exp_y    = 16'h0B01;
    exp_last = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (m_valid) break;
      tick();
    end
    for (int k = 0; k < 10; k++) begin
      check("stall m_valid held", m_valid, 1'b1);
      check("stall m_data held", m_data, 16'h0A01);
      check("stall s_ready low", s_ready, 1'b0);
      tick();
    end
    m_ready = 1'b1;
    send(16'h0B00, 16'h0B01, 1'b1);
    wait_idle();

    // Zero-length start is ignored; start while busy is ignored.
    start_seq(0);
    for (int k = 0; k < 3; k++) begin
      check("len0 busy", busy, 1'b0);
      tick();
    end
    start_seq(2);
    tick();
    send(16'h1000, 16'h1001, 1'b0);
    start   = 1'b1;
    seq_len = LEN_W'(5);
    tick();
    start   = 1'b0;
    send(16'h2000, 16'h2001, 1'b1);
    wait_idle();
    tick();
    check("restart ignored busy", busy, 1'b0);

    // Asynchronous reset during WAIT, then a clean restart.
    start_seq(2);
    tick();
    send(16'h3000, 16'h3001, 1'b0);
    tick();
    #2;
    rst = 1'b0;
    #1;
    check("async rst busy", busy, 1'b0);
    check("async rst x_in_valid", x_in_valid, 1'b0);
    check("async rst x_in", x_in, '0);
    check("async rst m_valid", m_valid, 1'b0);
    check("async rst s_ready", s_ready, 1'b0);
    do_reset();
    start_seq(1);
    check("re-INIT C_in_valid", C_in_valid, 3'b111);
    check("re-INIT h_in_valid", h_in_valid, 3'b111);
    tick();
    send(16'h4000, 16'h4001, 1'b1);
    wait_idle();

    // Silent stack.
    stub_en = 1'b0;
    start_seq(1);
    tick();
    send(16'h5000, 16'h5001, 1'b1);
    repeat (9) tick();
    check("silent stack early busy", busy, 1'b1);
    repeat (11) tick();
`ifdef LSTM_SEQ_TIMEOUT_EN
    check("timeout busy", busy, 1'b0);
    check("timeout_err set", timeout_err, 1'b1);
    check("timeout no m_valid", m_valid, 1'b0);
    sb.delete();
    stub_en = 1'b1;
    start_seq(1);
    check("timeout_err cleared by start", timeout_err, 1'b0);
    tick();
    send(16'h5100, 16'h5101, 1'b1);
    wait_idle();
`else
    check("no watchdog busy", busy, 1'b1);
    check("no watchdog timeout_err", timeout_err, 1'b0);
    check("no watchdog m_valid", m_valid, 1'b0);
    repeat (40) tick();
    check("no watchdog busy late", busy, 1'b1);
    stub_en = 1'b1;
    do_reset();
`endif

    // lstm_ready low blocks issue; release issues next cycle.
    start_seq(1);
    tick();
    s_data     = 16'h6000;
    s_valid    = 1'b1;
    exp_y      = 16'h6001;
    exp_last   = 1'b1;
    lstm_ready = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      check("lstm_ready low s_ready", s_ready, 1'b0);
      tick();
    end
    lstm_ready = 1'b1;
    #1;
    check("lstm_ready release s_ready", s_ready, 1'b1);
    tick();
    s_valid = 1'b0;
    check("issue next cycle x_in_valid", x_in_valid, 1'b1);
    check("issue next cycle x_in", x_in, 16'h6000);
    wait_idle();

    repeat (3) tick();
    check("scoreboard drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
